// File: rtl/vector_pls_bus_master.sv
// vector_pls_bus_master: serializes full-width vector loads/stores into narrow bus beats
// Optional macro VECTOR_PLS_BUS_SKIP_EMPTY_EN: skip store beats whose byte enables are all zero
module vector_pls_bus_master #(
    parameter int NUM_ELEMS = 8,
    parameter int ELEM_SIZE = 16,
    parameter int BUS_BITS = 32,
    parameter int ADDR_W = 16,
    localparam int VEC_BITS = NUM_ELEMS * ELEM_SIZE,
    localparam int BEATS = VEC_BITS / BUS_BITS,
    localparam int BUS_BE = BUS_BITS / 8,
    localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [VEC_BITS-1:0]   req_wdata,
    input  logic [VEC_BITS/8-1:0] req_byteen,
    output logic                  rsp_valid,
    output logic [VEC_BITS-1:0]   rsp_rdata,
    output logic                  bus_cmd_valid,
    input  logic                  bus_cmd_ready,
    output logic                  bus_cmd_we,
    output logic [ADDR_W-1:0]     bus_cmd_addr,
    output logic [BUS_BITS-1:0]   bus_cmd_wdata,
    output logic [BUS_BE-1:0]     bus_cmd_byteen,
    input  logic                  bus_rsp_valid,
    input  logic [BUS_BITS-1:0]   bus_rsp_rdata
);
    typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;
    state_t state;
    logic [KW-1:0] k;
    logic [KW-1:0] slot;
    logic we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BEATS-1:0][BUS_BITS-1:0] wdata_r;
    logic [BEATS-1:0][BUS_BITS-1:0] rdata_r;
    logic [BEATS-1:0][BUS_BE-1:0] be_r;
    logic [KW:0] nxt_first;
    logic [KW:0] nxt_after;
    logic last;
    assign last = k == KW'(BEATS - 1);
    assign slot = KW'(BEATS - 1) - k;
`ifdef VECTOR_PLS_BUS_SKIP_EMPTY_EN
    logic [BEATS-1:0][BUS_BE-1:0] req_be;
    assign req_be = req_byteen;
    function automatic logic [KW:0] nxt(input logic [BEATS-1:0][BUS_BE-1:0] be, input int from);
        nxt = '0;
        for (int j = BEATS - 1; j >= 0; j--)
            if (j >= from && |be[KW'(BEATS - 1 - j)]) nxt = {1'b1, KW'(j)};
    endfunction
    assign nxt_first = req_we ? nxt(req_be, 0) : {1'b1, {KW{1'b0}}};
    assign nxt_after = nxt(be_r, int'(k) + 1);
`else
    assign nxt_first = {1'b1, {KW{1'b0}}};
    assign nxt_after = {~last, k + 1'b1};
`endif
    assign rsp_rdata = rdata_r;
    assign bus_cmd_we = bus_cmd_valid & we_r;
    assign bus_cmd_addr = bus_cmd_valid ? addr_r + ADDR_W'(k) : '0;
    assign bus_cmd_wdata = bus_cmd_we ? wdata_r[slot] : '0;
    assign bus_cmd_byteen = bus_cmd_valid ? (we_r ? be_r[slot] : '1) : '0;
    // request FSM: capture, walk beats, collect read data, pulse completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k <= '0;
            we_r <= 1'b0;
            addr_r <= '0;
            wdata_r <= '0;
            be_r <= '0;
            rdata_r <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            bus_cmd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    we_r <= req_we;
                    addr_r <= req_addr;
                    wdata_r <= req_wdata;
                    be_r <= req_byteen;
                    req_ready <= 1'b0;
                    if (!req_we) rdata_r <= '0;
                    k <= nxt_first[KW-1:0];
                    if (nxt_first[KW]) begin
                        state <= CMD;
                        bus_cmd_valid <= 1'b1;
                    end else begin
                        state <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                CMD: if (bus_cmd_ready) begin
                    if (!we_r) begin
                        state <= RSP;
                        bus_cmd_valid <= 1'b0;
                    end else if (nxt_after[KW]) begin
                        k <= nxt_after[KW-1:0];
                    end else begin
                        state <= DONE;
                        bus_cmd_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                RSP: if (bus_rsp_valid) begin
                    rdata_r[slot] <= bus_rsp_rdata;
                    if (last) begin
                        state <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                        state <= CMD;
                        bus_cmd_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    k <= '0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_pls_bus_master.sv
// tb_vector_pls_bus_master: scoreboard bench with a vector-level reference model
module tb_vector_pls_bus_master;
    localparam int VB = 128, BB = 32, NB = 4, AW = 16;
`ifdef VECTOR_PLS_BUS_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    logic clk = 0, reset = 1;
    logic req_valid, req_ready, req_we, rsp_valid;
    logic [AW-1:0] req_addr, bus_cmd_addr;
    logic [VB-1:0] req_wdata, rsp_rdata;
    logic [15:0] req_byteen;
    logic bus_cmd_valid, bus_cmd_ready, bus_cmd_we, bus_rsp_valid;
    logic [BB-1:0] bus_cmd_wdata, bus_rsp_rdata;
    logic [3:0] bus_cmd_byteen;

    vector_pls_bus_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
        .bus_cmd_we(bus_cmd_we), .bus_cmd_addr(bus_cmd_addr), .bus_cmd_wdata(bus_cmd_wdata),
        .bus_cmd_byteen(bus_cmd_byteen), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we;
        logic [AW-1:0] addr;
        logic [BB-1:0] wdata;
        logic [3:0] be;
    } beat_t;

    beat_t exp_beats[$];
    logic [VB-1:0] exp_rsp[$];
    logic [BB-1:0] rd_words[$];
    int pass_cnt = 0, total = 0, cyc = 0, acc_cyc = 0;
    int rdy_mode = 0, stall_n = 0, rsp_delay = 0;
    logic [AW-1:0] stall_addr = '0;
    logic use_fixed = 0;
    logic [BB-1:0] fixed_w[4];
    logic [VB-1:0] last_rd = '0;
    logic rsp_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VB-1:0] act, input logic [VB-1:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // reference model: a vector is split MSB-first into bus words at consecutive addresses
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [VB-1:0] wd, input logic [15:0] be);
        logic [VB-1:0] rd = '0;
        int t = 0;
        for (int i = 0; i < NB; i++) begin
            beat_t b;
            logic [BB-1:0] w;
            b.we = we;
            b.addr = a + AW'(i);
            b.wdata = we ? BB'(wd >> (BB * (NB - 1 - i))) : '0;
            b.be = we ? 4'(be >> (4 * (NB - 1 - i))) : 4'hF;
            if (!we || b.be != 0 || !SKIP) exp_beats.push_back(b);
            if (!we) begin
                w = use_fixed ? fixed_w[i] : $urandom;
                rd_words.push_back(w);
                rd = {rd[VB-BB-1:0], w};
            end
        end
        if (!we) last_rd = rd;
        exp_rsp.push_back(last_rd);
        while (!req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) fail_now("req_ready_timeout");
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_byteen = be;
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 0; req_we = $urandom; req_addr = $urandom; req_wdata = {4{$urandom}}; req_byteen = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        int t = 0;
        while (t < 300) begin
            @(negedge clk);
            check("busy_req_ready", req_ready, 0);
            if (rsp_valid) break;
            t++;
        end
        if (t == 300) fail_now("rsp_timeout");
        lat = cyc - acc_cyc;
        @(posedge clk); #1;
    endtask

    // bus command acceptance
    initial begin
        bus_cmd_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) bus_cmd_ready = 1;
            else if (rdy_mode == 1) bus_cmd_ready = $urandom_range(0, 3) != 0;
            else if (bus_cmd_valid && bus_cmd_addr == stall_addr && stall_n < 3) begin
                bus_cmd_ready = 0;
                stall_n++;
            end else bus_cmd_ready = 1;
        end
    end

    // bus read responder, plus stray response pulses while a store is on the bus
    initial begin
        int d;
        bus_rsp_valid = 0;
        bus_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus_rsp_valid = 0;
            if (!reset && bus_cmd_valid && bus_cmd_ready && !bus_cmd_we) begin
                d = rsp_delay != 0 ? rsp_delay : $urandom_range(1, 3);
                repeat (d) @(posedge clk);
                #1;
                if (!reset && rd_words.size() > 0) begin
                    bus_rsp_valid = 1;
                    bus_rsp_rdata = rd_words.pop_front();
                    @(posedge clk); #1;
                    bus_rsp_valid = 0;
                end
                bus_rsp_rdata = $urandom;
            end else if (!reset && bus_cmd_valid && bus_cmd_we && $urandom_range(0, 3) == 0) begin
                bus_rsp_valid = 1;
                bus_rsp_rdata = $urandom;
            end
        end
    end

    // monitor: every valid command cycle must match the head expected beat (also proves stall stability)
    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (bus_cmd_valid) begin
                check("cmd_req_ready", req_ready, 0);
                if (exp_beats.size() == 0) fail_now("cmd_unexpected");
                else begin
                    b = exp_beats[0];
                    check("cmd_we", bus_cmd_we, b.we);
                    check("cmd_addr", bus_cmd_addr, b.addr);
                    check("cmd_byteen", bus_cmd_byteen, b.be);
                    if (b.we) check("cmd_wdata", bus_cmd_wdata, b.wdata);
                    if (bus_cmd_ready) void'(exp_beats.pop_front());
                end
            end
            if (rsp_valid) begin
                check("rsp_single_pulse", rsp_prev, 0);
                if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
                else check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
            end
            rsp_prev <= rsp_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, t;
        logic [15:0] be;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_byteen = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_cmd_valid", bus_cmd_valid, 0);
        check("rst_cmd_we", bus_cmd_we, 0);
        check("rst_cmd_addr", bus_cmd_addr, 0);
        check("rst_cmd_wdata", bus_cmd_wdata, 0);
        check("rst_cmd_byteen", bus_cmd_byteen, 0);
        reset = 0;
        @(posedge clk); #1;

        issue(1, 16'h0100, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'hFFFF);
        wait_rsp(lat);
        check("store_latency", lat, 5);

        rdy_mode = 2; stall_addr = 16'h0301; stall_n = 0;
        issue(1, 16'h0300, {4{$urandom}}, 16'hFFFF);
        wait_rsp(lat);
        check("stall_latency", lat, 8);
        check("stall_cycles", stall_n, 3);
        rdy_mode = 0;

        use_fixed = 1; rsp_delay = 2;
        fixed_w = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        issue(0, 16'h0200, '0, '0);
        wait_rsp(lat);
        check("load_rdata_hold", rsp_rdata, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
        use_fixed = 0; rsp_delay = 0;

        issue(1, 16'hFFFE, {4{$urandom}}, 16'hFFFF);
        wait_rsp(lat);

        issue(0, 16'h0400, '0, '0);
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (bus_cmd_valid && bus_cmd_ready && bus_cmd_addr == 16'h0402) break;
            t++;
        end
        if (t == 100) fail_now("beat2_timeout");
        #2 reset = 1;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_rdata", rsp_rdata, 0);
        check("midrst_cmd_valid", bus_cmd_valid, 0);
        check("midrst_cmd_addr", bus_cmd_addr, 0);
        exp_beats.delete(); exp_rsp.delete(); rd_words.delete();
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        repeat (5) @(posedge clk);
        #1;
        issue(0, 16'h0500, '0, '0);
        wait_rsp(lat);
        issue(1, 16'h0600, {4{$urandom}}, 16'h0F0F);
        wait_rsp(lat);

        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: be = 16'hFFFF;
                1: be = 16'h0000;
                default: be = 16'($urandom);
            endcase
            issue(1'($urandom), 16'($urandom), {4{$urandom}}, be);
            wait_rsp(lat);
        end
        repeat (3) @(posedge clk);
        #1;
        check("beats_drained", exp_beats.size(), 0);
        check("rsps_drained", exp_rsp.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
